bios_cmd_master: RTL and testbench

- Host-side initiator for the BIOS byte-command protocol.
- Takes word-level requests (NOP, BOOT, RST, READ, WRITE) from an on-chip controller, such as a debug bridge or self-test sequencer.
- Serialises each request into BIOS opcode/argument bytes on an AXI-stream byte output, which drives the bios module's input stream.
- For READ, it captures the single response byte that bios returns on its output stream, then reports completion.

---
 rtl/bios_cmd_master.sv | 252 +++++++++++++++++++++++++
 tb/tb_bios_cmd_master.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bios_cmd_master.sv
// Host-side BIOS byte-command initiator: serialises word requests into opcode/argument
// bytes on an AXI-stream output and captures the single READ response byte.
module bios_cmd_master #(
    parameter int unsigned ADDR_WIDTH  = 31,
    parameter int unsigned DATA_WIDTH  = 31,
    parameter int unsigned RSP_TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [2:0]            i_req_op,
    input  logic [ADDR_WIDTH:0]   i_req_addr,
    input  logic [DATA_WIDTH:0]   i_req_wdata,
    input  logic [3:0]            i_req_be,
    output logic                  o_done,
    output logic [7:0]            o_rsp_data,
    output logic                  o_rsp_err,
    output logic                  o_booted,
    output logic [7:0]            o_data,
    output logic                  o_valid,
    input  logic                  i_out_ready,
    input  logic [7:0]            i_data,
    input  logic                  i_valid,
    output logic                  o_in_ready
);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_RSP, DONE, BOOTED} state_t;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_BOOT  = 3'd1;
    localparam logic [2:0] OP_RST   = 3'd2;
    localparam logic [2:0] OP_READ  = 3'd3;
    localparam logic [2:0] OP_WRITE = 3'd4;
    localparam int unsigned CNT_W = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT + 1) : 1;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [31:0]       addr_q, addr_d;
    logic [7:0]        seq_q [16];
    logic [7:0]        seq_d [16];
    logic [3:0]        len_q, len_d;
    logic [3:0]        idx_q, idx_d;
    logic              hi_pend_q, hi_pend_d;
    logic              lo_pend_q, lo_pend_d;
    logic [3:0]        lo_last_q, lo_last_d;
    logic              hi_valid_q, hi_valid_d;
    logic              lo_valid_q, lo_valid_d;
    logic [15:0]       hi_tag_q, hi_tag_d;
    logic [15:0]       lo_tag_q, lo_tag_d;
    logic              valid_q, valid_d;
    logic [7:0]        data_q, data_d;
    logic              done_q, done_d;
    logic [7:0]        rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              booted_q, booted_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [7:0]        seq_n [16];
    logic [3:0]        len_n;
    logic              is_mem, hi_snd, lo_snd, illegal, accept, tx, timeout_hit;

    assign o_req_ready = (state_q == IDLE) && !rst;
    assign o_in_ready  = !rst;
    assign o_valid     = valid_q;
    assign o_data      = data_q;
    assign o_done      = done_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_booted    = booted_q;

    // Whole byte sequence is built from the live request at acceptance; the cache
    // cannot change before then because only one request is ever in flight.
    always_comb begin
        seq_n   = '{default: 8'h00};
        len_n   = '0;
        illegal = (i_req_op > OP_WRITE);
        is_mem  = (i_req_op == OP_READ) || (i_req_op == OP_WRITE);
        hi_snd  = is_mem && (!hi_valid_q || (hi_tag_q != i_req_addr[31:16]));
        lo_snd  = is_mem && (!lo_valid_q || (lo_tag_q != i_req_addr[15:0]));
        if (hi_snd) begin
            seq_n[len_n] = 8'h09;             len_n = len_n + 4'd1;
            seq_n[len_n] = i_req_addr[31:24]; len_n = len_n + 4'd1;
            seq_n[len_n] = i_req_addr[23:16]; len_n = len_n + 4'd1;
        end
        if (lo_snd) begin
            seq_n[len_n] = 8'h08;             len_n = len_n + 4'd1;
            seq_n[len_n] = i_req_addr[15:8];  len_n = len_n + 4'd1;
            seq_n[len_n] = i_req_addr[7:0];   len_n = len_n + 4'd1;
        end
        case (i_req_op)
            OP_NOP:  begin seq_n[len_n] = 8'h00; len_n = len_n + 4'd1; end
            OP_BOOT: begin seq_n[len_n] = 8'h01; len_n = len_n + 4'd1; end
            OP_RST:  begin seq_n[len_n] = 8'h02; len_n = len_n + 4'd1; end
            OP_READ: begin seq_n[len_n] = 8'h03; len_n = len_n + 4'd1; end
            OP_WRITE: begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (i_req_be[i]) begin
                        seq_n[len_n] = 8'h04 + 8'(i);          len_n = len_n + 4'd1;
                        seq_n[len_n] = i_req_wdata[8*i +: 8];  len_n = len_n + 4'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign accept      = i_req_valid && o_req_ready;
    assign tx          = valid_q && i_out_ready;
    assign timeout_hit = (RSP_TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == RSP_TIMEOUT);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        seq_d      = seq_q;
        len_d      = len_q;
        idx_d      = idx_q;
        hi_pend_d  = hi_pend_q;
        lo_pend_d  = lo_pend_q;
        lo_last_d  = lo_last_q;
        hi_valid_d = hi_valid_q;
        lo_valid_d = lo_valid_q;
        hi_tag_d   = hi_tag_q;
        lo_tag_d   = lo_tag_q;
        valid_d    = valid_q;
        data_d     = data_q;
        done_d     = 1'b0;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        booted_d   = booted_q;
        cnt_d      = cnt_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d      = i_req_op;
                    addr_d    = i_req_addr[31:0];
                    seq_d     = seq_n;
                    len_d     = len_n;
                    idx_d     = '0;
                    hi_pend_d = hi_snd;
                    lo_pend_d = lo_snd;
                    lo_last_d = hi_snd ? 4'd5 : 4'd2;
                    if (len_n == 4'd0) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        rsp_data_d = '0;
                        rsp_err_d  = illegal;
                    end else begin
                        state_d = SEND;
                        valid_d = 1'b1;
                        data_d  = seq_n[0];
                    end
                end
            end
            SEND: begin
                if (tx) begin
                    if (hi_pend_q && (idx_q == 4'd2)) begin
                        hi_valid_d = 1'b1;
                        hi_tag_d   = addr_q[31:16];
                    end
                    if (lo_pend_q && (idx_q == lo_last_q)) begin
                        lo_valid_d = 1'b1;
                        lo_tag_d   = addr_q[15:0];
                    end
                    if (idx_q == (len_q - 4'd1)) begin
                        valid_d = 1'b0;
                        if (op_q == OP_READ) begin
                            state_d = WAIT_RSP;
                            cnt_d   = '0;
                        end else begin
                            state_d    = DONE;
                            done_d     = 1'b1;
                            rsp_data_d = '0;
                            rsp_err_d  = 1'b0;
                            if (op_q == OP_BOOT) booted_d = 1'b1;
                        end
                    end else begin
                        idx_d  = idx_q + 4'd1;
                        data_d = seq_q[idx_d];
                    end
                end
            end
            WAIT_RSP: begin
                if (i_valid) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    rsp_data_d = i_data;
                    rsp_err_d  = 1'b0;
                end else if (timeout_hit) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = (op_q == OP_BOOT) ? BOOTED : IDLE;
            BOOTED:  state_d = BOOTED;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            seq_q      <= '{default: 8'h00};
            len_q      <= '0;
            idx_q      <= '0;
            hi_pend_q  <= 1'b0;
            lo_pend_q  <= 1'b0;
            lo_last_q  <= '0;
            hi_valid_q <= 1'b0;
            lo_valid_q <= 1'b0;
            hi_tag_q   <= '0;
            lo_tag_q   <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            done_q     <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            booted_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            seq_q      <= seq_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            hi_pend_q  <= hi_pend_d;
            lo_pend_q  <= lo_pend_d;
            lo_last_q  <= lo_last_d;
            hi_valid_q <= hi_valid_d;
            lo_valid_q <= lo_valid_d;
            hi_tag_q   <= hi_tag_d;
            lo_tag_q   <= lo_tag_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            done_q     <= done_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            booted_q   <= booted_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_bios_cmd_master.sv
// Directed self-checking bench for bios_cmd_master: byte sequences, address cache,
// stalls, READ response/timeout, BOOT, mid-sequence reset and illegal op.
module tb_bios_cmd_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [2:0]  i_req_op;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic [3:0]  i_req_be;
    logic        o_done;
    logic [7:0]  o_rsp_data;
    logic        o_rsp_err;
    logic        o_booted;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        i_out_ready;
    logic [7:0]  i_data;
    logic        i_valid;
    logic        o_in_ready;

    int          vecs = 0;
    int          errs = 0;

    logic [127:0] got_vec;
    int           got_n;
    int           done_cyc;
    int           last_hs;
    int           unstable;
    logic [7:0]   got_rsp;
    logic         got_err;

    always #5 clk = ~clk;

    bios_cmd_master #(
        .ADDR_WIDTH (31),
        .DATA_WIDTH (31),
        .RSP_TIMEOUT(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_req_valid(i_req_valid),
        .o_req_ready(o_req_ready),
        .i_req_op   (i_req_op),
        .i_req_addr (i_req_addr),
        .i_req_wdata(i_req_wdata),
        .i_req_be   (i_req_be),
        .o_done     (o_done),
        .o_rsp_data (o_rsp_data),
        .o_rsp_err  (o_rsp_err),
        .o_booted   (o_booted),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_out_ready(i_out_ready),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .o_in_ready (o_in_ready)
    );

    // Waits (bounded) for o_req_ready, presents one request for one cycle.
    task automatic issue(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be);
        int w = 0;
        while (o_req_ready !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        vecs++;
        if (o_req_ready !== 1'b1) begin
            errs++;
            $display("FAIL issue_ready: o_req_ready=%b after %0d cycles, expected 1", o_req_ready, w);
        end
        i_req_valid = 1'b1;
        i_req_op    = op;
        i_req_addr  = addr;
        i_req_wdata = wd;
        i_req_be    = be;
        @(negedge clk);
        i_req_valid = 1'b0;
    endtask

    // Plays the bios side: accepts bytes (optionally with random stalls), answers a
    // READ opcode one cycle after its handshake, and stops at o_done.
    task automatic capture(input bit rnd, input bit respond, input logic [7:0] rbyte, input int maxc);
        int         rsp_at = -1;
        logic       stalled = 1'b0;
        logic [7:0] held = '0;
        got_vec  = '0;
        got_n    = 0;
        done_cyc = -1;
        last_hs  = -1;
        unstable = 0;
        got_rsp  = 'x;
        got_err  = 'x;
        for (int c = 0; c < maxc; c++) begin
            if (c > 0) @(negedge clk);
            if (o_done === 1'b1) begin
                done_cyc = c;
                got_rsp  = o_rsp_data;
                got_err  = o_rsp_err;
                break;
            end
            if (stalled && (o_valid !== 1'b1 || o_data !== held)) unstable++;
            i_out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            i_valid     = (c == rsp_at);
            i_data      = rbyte;
            if (o_valid === 1'b1 && i_out_ready) begin
                got_vec = {got_vec[119:0], o_data};
                got_n++;
                last_hs = c;
                if (respond && o_data == 8'h03) rsp_at = c + 1;
            end
            stalled = (o_valid === 1'b1) && !i_out_ready;
            held    = o_data;
        end
        i_valid     = 1'b0;
        i_out_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        i_req_valid = 0; i_req_op = 0; i_req_addr = 0; i_req_wdata = 0; i_req_be = 0;
        i_out_ready = 1'b1; i_valid = 1'b0; i_data = 0;
        repeat (3) @(negedge clk);
        vecs++;
        if ({o_req_ready, o_valid, o_data, o_done, o_rsp_data, o_rsp_err, o_booted, o_in_ready} !== 21'h0) begin
            errs++;
            $display("FAIL reset_vals: rdy=%b vld=%b data=%h done=%b rsp=%h err=%b booted=%b in_rdy=%b, expected all 0",
                     o_req_ready, o_valid, o_data, o_done, o_rsp_data, o_rsp_err, o_booted, o_in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        vecs++;
        if (o_req_ready !== 1'b1 || o_in_ready !== 1'b1 || o_valid !== 1'b0) begin
            errs++;
            $display("FAIL reset_release: rdy=%b in_rdy=%b vld=%b, expected 1 1 0", o_req_ready, o_in_ready, o_valid);
        end
    endtask

    task automatic test_write_prefix;
        issue(3'd4, 32'h0000_1234, 32'hAABB_CCDD, 4'b0101);
        capture(1'b0, 1'b0, 8'h00, 60);
        vecs++;
        if (got_n != 10 || got_vec !== 128'h09_00_00_08_12_34_04_DD_06_BB) begin
            errs++;
            $display("FAIL write1_bytes: got %0d bytes %h, expected 10 bytes 090000081234 04DD06BB", got_n, got_vec);
        end
        vecs++;
        if (done_cyc != 10 || got_err !== 1'b0) begin
            errs++;
            $display("FAIL write1_done: done at %0d err=%b, expected 10 err=0", done_cyc, got_err);
        end
    endtask

    task automatic test_write_cached;
        issue(3'd4, 32'h0000_1234, 32'hAABB_CCDD, 4'b1000);
        capture(1'b0, 1'b0, 8'h00, 30);
        vecs++;
        if (got_n != 2 || got_vec !== 128'h07_AA) begin
            errs++;
            $display("FAIL write2_bytes: got %0d bytes %h, expected 2 bytes 07AA", got_n, got_vec);
        end
        vecs++;
        if (done_cyc != 2 || got_err !== 1'b0) begin
            errs++;
            $display("FAIL write2_done: done at %0d err=%b, expected 2 err=0", done_cyc, got_err);
        end
    endtask

    task automatic test_read;
        issue(3'd3, 32'h0001_1234, 32'h0, 4'h0);
        capture(1'b0, 1'b1, 8'h5A, 40);
        vecs++;
        if (got_n != 4 || got_vec !== 128'h09_00_01_03) begin
            errs++;
            $display("FAIL read_bytes: got %0d bytes %h, expected 4 bytes 09000103", got_n, got_vec);
        end
        vecs++;
        if (got_rsp !== 8'h5A || got_err !== 1'b0 || done_cyc - last_hs != 2) begin
            errs++;
            $display("FAIL read_rsp: rsp=%h err=%b lat=%0d, expected 5a 0 2", got_rsp, got_err, done_cyc - last_hs);
        end
    endtask

    task automatic test_stall;
        issue(3'd4, 32'h0001_1234, 32'h1122_3344, 4'hF);
        capture(1'b1, 1'b0, 8'h00, 200);
        vecs++;
        if (got_n != 8 || got_vec !== 128'h04_44_05_33_06_22_07_11) begin
            errs++;
            $display("FAIL stall_bytes: got %0d bytes %h, expected 8 bytes 0444053306220711", got_n, got_vec);
        end
        vecs++;
        if (unstable != 0) begin
            errs++;
            $display("FAIL stall_hold: %0d stalled cycles changed o_data/o_valid, expected 0", unstable);
        end
        vecs++;
        if (done_cyc - last_hs != 1 || got_err !== 1'b0) begin
            errs++;
            $display("FAIL stall_done: lat=%0d err=%b, expected 1 0", done_cyc - last_hs, got_err);
        end
    endtask

    task automatic test_timeout;
        issue(3'd3, 32'h0002_1234, 32'h0, 4'h0);
        capture(1'b0, 1'b0, 8'h00, 80);
        vecs++;
        if (got_n != 4 || got_vec !== 128'h09_00_02_03) begin
            errs++;
            $display("FAIL to_bytes: got %0d bytes %h, expected 4 bytes 09000203", got_n, got_vec);
        end
        vecs++;
        if (done_cyc - last_hs != 17 || got_err !== 1'b1 || got_rsp !== 8'h00) begin
            errs++;
            $display("FAIL to_done: lat=%0d err=%b rsp=%h, expected 17 1 00", done_cyc - last_hs, got_err, got_rsp);
        end
        i_valid = 1'b1;
        i_data  = 8'h77;
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        issue(3'd3, 32'h0002_1234, 32'h0, 4'h0);
        capture(1'b0, 1'b1, 8'h3C, 40);
        vecs++;
        if (got_n != 1 || got_vec !== 128'h03 || got_rsp !== 8'h3C || got_err !== 1'b0) begin
            errs++;
            $display("FAIL late_discard: n=%0d bytes %h rsp=%h err=%b, expected 1 03 3c 0", got_n, got_vec, got_rsp, got_err);
        end
    endtask

    task automatic test_boot;
        issue(3'd1, 32'h0, 32'h0, 4'h0);
        capture(1'b0, 1'b0, 8'h00, 20);
        vecs++;
        if (got_n != 1 || got_vec !== 128'h01 || done_cyc != 1 || o_booted !== 1'b1) begin
            errs++;
            $display("FAIL boot_seq: n=%0d bytes %h done at %0d booted=%b, expected 1 01 1 1", got_n, got_vec, done_cyc, o_booted);
        end
        repeat (3) @(negedge clk);
        vecs++;
        if (o_req_ready !== 1'b0 || o_booted !== 1'b1 || o_valid !== 1'b0) begin
            errs++;
            $display("FAIL booted_hold: rdy=%b booted=%b vld=%b, expected 0 1 0", o_req_ready, o_booted, o_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vecs++;
        if (o_booted !== 1'b0) begin
            errs++;
            $display("FAIL boot_rst: booted=%b, expected 0", o_booted);
        end
        issue(3'd4, 32'h0002_1234, 32'h0000_00DD, 4'b0001);
        capture(1'b0, 1'b0, 8'h00, 40);
        vecs++;
        if (got_n != 8 || got_vec !== 128'h09_00_02_08_12_34_04_DD) begin
            errs++;
            $display("FAIL prefix_resend: got %0d bytes %h, expected 8 bytes 0900020812 3404DD", got_n, got_vec);
        end
    endtask

    task automatic test_reset_midop;
        i_out_ready = 1'b0;
        issue(3'd4, 32'h0003_0000, 32'h1122_3344, 4'hF);
        vecs++;
        if (o_valid !== 1'b1 || o_data !== 8'h09) begin
            errs++;
            $display("FAIL midop_first: vld=%b data=%h, expected 1 09", o_valid, o_data);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vecs++;
        if (o_valid !== 1'b0 || o_data !== 8'h00 || o_req_ready !== 1'b0) begin
            errs++;
            $display("FAIL midop_rst: vld=%b data=%h rdy=%b, expected 0 00 0", o_valid, o_data, o_req_ready);
        end
        rst = 1'b0;
        i_out_ready = 1'b1;
        @(negedge clk);
        vecs++;
        if (o_req_ready !== 1'b1 || o_valid !== 1'b0) begin
            errs++;
            $display("FAIL midop_idle: rdy=%b vld=%b, expected 1 0", o_req_ready, o_valid);
        end
    endtask

    task automatic test_illegal;
        issue(3'd6, 32'h0000_1234, 32'h0, 4'hF);
        capture(1'b0, 1'b0, 8'h00, 20);
        vecs++;
        if (got_n != 0 || done_cyc != 0 || got_err !== 1'b1 || got_rsp !== 8'h00) begin
            errs++;
            $display("FAIL illegal: n=%0d done at %0d err=%b rsp=%h, expected 0 0 1 00", got_n, done_cyc, got_err, got_rsp);
        end
    endtask

    initial begin
        test_reset();
        test_write_prefix();
        test_write_cached();
        test_read();
        test_stall();
        test_timeout();
        test_boot();
        test_reset_midop();
        test_illegal();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
